// File: rtl/multi_chan_accum.sv
// multi_chan_accum: NUM_CH-channel accumulator bank with sticky overflow flags and a
// clear-on-read dump stream over a valid/ready port.
// Optional build macro MULTI_CHAN_ACCUM_SATURATE_EN: clamp to all-ones on carry out
// instead of wrapping.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | accepting samples (o_ready=1), waiting for a dump request
// DUMP  | streaming acc[ptr]/ovf[ptr]; each handshake clears that channel
module multi_chan_accum #(
  parameter int NUM_CH    = 4,
  parameter int BUS_WIDTH = 4,
  parameter int ACC_WIDTH = 8,
  localparam int CH_W     = $clog2(NUM_CH)
) (
  input  logic                 i_clk,
  input  logic                 i_arst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [CH_W-1:0]      i_ch,
  input  logic [BUS_WIDTH-1:0] i_din,
  input  logic                 i_dump,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [CH_W-1:0]      o_ch,
  output logic [ACC_WIDTH-1:0] o_data,
  output logic                 o_ovf,
  output logic                 o_busy
);

  if (ACC_WIDTH < BUS_WIDTH) begin : g_bad_width
    $error("multi_chan_accum: ACC_WIDTH must be >= BUS_WIDTH");
  end

  if (NUM_CH < 2) begin : g_bad_num_ch
    $error("multi_chan_accum: NUM_CH must be >= 2");
  end

  localparam logic [CH_W-1:0] LAST_PTR = CH_W'(NUM_CH - 1);
  localparam logic [CH_W:0]   CH_LIMIT = (CH_W + 1)'(NUM_CH);

  typedef enum logic {
    IDLE = 1'b0,
    DUMP = 1'b1
  } state_t;

  state_t                 state;
  logic [CH_W-1:0]        ptr;
  logic [ACC_WIDTH-1:0]   acc [NUM_CH];
  logic                   ovf [NUM_CH];

  logic                   ch_ok;
  logic [CH_W-1:0]        ch_idx;
  logic                   accept;
  logic                   take;
  logic [ACC_WIDTH:0]     sum;
  logic                   carry;
  logic [ACC_WIDTH-1:0]   add_next;

  // Out-of-range channel tags are dropped; ch_idx is forced in range so the read is always legal.
  always_comb begin
    ch_ok  = ({1'b0, i_ch} < CH_LIMIT);
    ch_idx = ch_ok ? i_ch : '0;
    accept = i_valid && o_ready && ch_ok;
    take   = o_valid && i_ready;
  end

  // One-bit-wider add so the carry out is visible; the carry drives the sticky flag.
  always_comb begin
    sum   = {1'b0, acc[ch_idx]} + {{(ACC_WIDTH + 1 - BUS_WIDTH){1'b0}}, i_din};
    carry = sum[ACC_WIDTH];
`ifdef MULTI_CHAN_ACCUM_SATURATE_EN
    add_next = carry ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
`else
    add_next = sum[ACC_WIDTH-1:0];
`endif
  end

  // Control FSM; o_valid/o_busy/o_ready are registered alongside the state so reset drops them at once.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
      o_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (i_dump) begin
            state   <= DUMP;
            ptr     <= '0;
            o_valid <= 1'b1;
            o_busy  <= 1'b1;
            o_ready <= 1'b0;
          end
        end
        DUMP: begin
          if (take) begin
            if (ptr == LAST_PTR) begin
              state   <= IDLE;
              ptr     <= '0;
              o_valid <= 1'b0;
              o_busy  <= 1'b0;
              o_ready <= 1'b1;
            end else begin
              ptr <= ptr + 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          ptr     <= '0;
          o_valid <= 1'b0;
          o_busy  <= 1'b0;
          o_ready <= 1'b1;
        end
      endcase
    end
  end

  // Accumulator bank: samples only land in IDLE and clears only happen in DUMP, so they never collide.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc[i] <= '0;
        ovf[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (take && (ptr == CH_W'(i))) begin
          acc[i] <= '0;
          ovf[i] <= 1'b0;
        end else if (accept && (ch_idx == CH_W'(i))) begin
          acc[i] <= add_next;
          ovf[i] <= ovf[i] | carry;
        end
      end
    end
  end

  // Presented word is a plain read of stable registers, so it holds under backpressure.
  always_comb begin
    o_ch   = ptr;
    o_data = acc[ptr];
    o_ovf  = ovf[ptr];
  end

endmodule

// File: tb/tb_multi_chan_accum.sv
// Self-checking bench for multi_chan_accum: directed scenarios plus a randomized phase,
// checked against an integer model of the per-channel sums and sticky flags.
module tb_multi_chan_accum;

  localparam int NUM_CH    = 4;
  localparam int BUS_WIDTH = 4;
  localparam int ACC_WIDTH = 8;
  localparam int CH_W      = $clog2(NUM_CH);
  localparam int MAXV      = (1 << ACC_WIDTH) - 1;
`ifdef MULTI_CHAN_ACCUM_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic                 i_clk;
  logic                 i_arst_n;
  logic                 i_valid;
  logic                 o_ready;
  logic [CH_W-1:0]      i_ch;
  logic [BUS_WIDTH-1:0] i_din;
  logic                 i_dump;
  logic                 o_valid;
  logic                 i_ready;
  logic [CH_W-1:0]      o_ch;
  logic [ACC_WIDTH-1:0] o_data;
  logic                 o_ovf;
  logic                 o_busy;

  int n_checks = 0;
  int n_errors = 0;

  int m_acc [NUM_CH];
  bit m_ovf [NUM_CH];

  multi_chan_accum #(
    .NUM_CH   (NUM_CH),
    .BUS_WIDTH(BUS_WIDTH),
    .ACC_WIDTH(ACC_WIDTH)
  ) dut (
    .i_clk   (i_clk),
    .i_arst_n(i_arst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_ch    (i_ch),
    .i_din   (i_din),
    .i_dump  (i_dump),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_ch    (o_ch),
    .o_data  (o_data),
    .o_ovf   (o_ovf),
    .o_busy  (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_clear_all();
    for (int c = 0; c < NUM_CH; c++) begin
      m_acc[c] = 0;
      m_ovf[c] = 1'b0;
    end
  endfunction

  function automatic void model_add(input int ch, input int din);
    int s;
    s = m_acc[ch] + din;
    if (s > MAXV) begin
      m_ovf[ch] = 1'b1;
      m_acc[ch] = SAT ? MAXV : s - (MAXV + 1);
    end else begin
      m_acc[ch] = s;
    end
  endfunction

  // One IDLE cycle: drive at negedge, check idle outputs, commit to the model on the posedge.
  task automatic idle_cycle(input bit v, input int ch, input int din, input bit dump);
    @(negedge i_clk);
    i_valid = v;
    i_ch    = CH_W'(ch);
    i_din   = BUS_WIDTH'(din);
    i_dump  = dump;
    i_ready = 1'($urandom);
    chk("idle_ready", 32'(o_ready), 32'd1);
    chk("idle_valid", 32'(o_valid), 32'd0);
    chk("idle_busy",  32'(o_busy),  32'd0);
    @(posedge i_clk);
    if (v) model_add(ch, din);
  endtask

  // Walk the dump stream, checking every presented word; stalls are forced at stall_ch or random.
  task automatic run_dump(input int stall_ch, input int stall_n, input bit rnd_ready);
    int k = 0;
    int cyc = 0;
    int stalls = 0;
    while (k < NUM_CH && cyc < 200) begin
      @(negedge i_clk);
      i_valid = 1'($urandom);
      i_ch    = '0;
      i_din   = BUS_WIDTH'($urandom);
      i_dump  = 1'($urandom);
      chk("dump_valid", 32'(o_valid), 32'd1);
      chk("dump_busy",  32'(o_busy),  32'd1);
      chk("dump_ready", 32'(o_ready), 32'd0);
      chk("dump_ch",    32'(o_ch),    32'(k));
      chk("dump_data",  32'(o_data),  32'(m_acc[k]));
      chk("dump_ovf",   32'(o_ovf),   32'(m_ovf[k]));
      if (k == stall_ch && stalls < stall_n) begin
        i_ready = 1'b0;
        stalls++;
      end else if (rnd_ready) begin
        i_ready = 1'(($urandom % 3) != 0);
      end else begin
        i_ready = 1'b1;
      end
      @(posedge i_clk);
      if (i_ready) begin
        m_acc[k] = 0;
        m_ovf[k] = 1'b0;
        k++;
      end
      cyc++;
    end
    if (k != NUM_CH) chk("dump_timeout", 32'(k), 32'(NUM_CH));
    if (!rnd_ready) chk("dump_len", 32'(cyc), 32'(NUM_CH + stall_n));
  endtask

  initial begin
    i_arst_n = 1'b0;
    i_valid  = 1'b0;
    i_ch     = '0;
    i_din    = '0;
    i_dump   = 1'b0;
    i_ready  = 1'b0;
    model_clear_all();

    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_busy",  32'(o_busy),  32'd0);
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_ch",    32'(o_ch),    32'd0);
    chk("rst_data",  32'(o_data),  32'd0);
    chk("rst_ovf",   32'(o_ovf),   32'd0);
    @(negedge i_clk);
    i_arst_n = 1'b1;

    // accumulate then dump with no backpressure
    idle_cycle(1'b1, 0, 5, 1'b0);
    idle_cycle(1'b1, 0, 7, 1'b0);
    idle_cycle(1'b1, 3, 9, 1'b0);
    chk("t1_model_ch0", 32'(m_acc[0]), 32'd12);
    idle_cycle(1'b0, 0, 0, 1'b1);
    run_dump(-1, 0, 1'b0);

    // clear-on-read: immediate second dump sees zeros
    idle_cycle(1'b0, 0, 0, 1'b1);
    run_dump(-1, 0, 1'b0);

    // overflow on ch1: 18 x 15 = 270
    for (int n = 0; n < 18; n++) idle_cycle(1'b1, 1, 15, 1'b0);
    idle_cycle(1'b0, 0, 0, 1'b1);
    run_dump(-1, 0, 1'b0);

    // backpressure at ch2 for 3 cycles with ch0 traffic during the stall
    idle_cycle(1'b1, 2, 3, 1'b0);
    idle_cycle(1'b1, 0, 1, 1'b0);
    idle_cycle(1'b0, 0, 0, 1'b1);
    run_dump(2, 3, 1'b0);

    // sample accepted in the same cycle as the dump request
    idle_cycle(1'b1, 2, 6, 1'b1);
    run_dump(-1, 0, 1'b0);

    // reset in the middle of a dump at ptr=2
    idle_cycle(1'b1, 1, 4, 1'b0);
    idle_cycle(1'b1, 2, 8, 1'b0);
    idle_cycle(1'b1, 3, 2, 1'b1);
    for (int k = 0; k < 2; k++) begin
      @(negedge i_clk);
      i_valid = 1'b0;
      i_dump  = 1'b0;
      i_ready = 1'b1;
      chk("abort_pre_ch", 32'(o_ch), 32'(k));
      @(posedge i_clk);
      m_acc[k] = 0;
      m_ovf[k] = 1'b0;
    end
    @(negedge i_clk);
    i_ready = 1'b0;
    chk("abort_ptr2_ch",   32'(o_ch),   32'd2);
    chk("abort_ptr2_data", 32'(o_data), 32'(m_acc[2]));
    #2;
    i_arst_n = 1'b0;
    #1;
    model_clear_all();
    chk("abort_valid", 32'(o_valid), 32'd0);
    chk("abort_busy",  32'(o_busy),  32'd0);
    chk("abort_data",  32'(o_data),  32'd0);
    @(negedge i_clk);
    i_arst_n = 1'b1;
    chk("abort_ready", 32'(o_ready), 32'd1);
    idle_cycle(1'b0, 0, 0, 1'b1);
    run_dump(-1, 0, 1'b0);

    // randomized traffic with occasional dumps and random backpressure
    for (int n = 0; n < 400; n++) begin
      bit do_dump;
      do_dump = (($urandom % 12) == 0);
      idle_cycle(1'($urandom), int'($urandom % NUM_CH), int'($urandom % 16), do_dump);
      if (do_dump) run_dump(-1, 0, 1'b1);
    end
    idle_cycle(1'b0, 0, 0, 1'b1);
    run_dump(-1, 0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
